// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS main control: opcodes, FSM state
// codes and the datapath select encodings seen by the ALU decoder and muxes.
package multicycle_main_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_B_REG     = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH2 = 2'b11
  } src_b_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  function automatic logic opcode_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_main_control.sv
// Moore main-control FSM for a multicycle MIPS datapath; all strobes decode
// directly from the state register, only pc_en and illegal_op see live inputs.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  logic   is_store_q;

  // NOTE: state is updated with non-blocking assignments so every reader in
  // this cycle sees the pre-edge value regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      is_store_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          // lw and sw differ only in bit 3; MEMADR steers on this copy
          // because the instruction register may already be changing.
          is_store_q <= opcode[3];
          case (opcode)
            OP_LW, OP_SW: state_q <= S_MEMADR;
            OP_RTYPE:     state_q <= S_EXEC;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_ADDI:      state_q <= S_ADDIEX;
            OP_J:         state_q <= S_JUMP;
            default:      state_q <= S_FETCH;
          endcase
        end
        S_MEMADR: state_q <= is_store_q ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= S_MEMWB;
        S_EXEC:   state_q <= S_ALUWB;
        S_ADDIEX: state_q <= S_ADDIWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path through the
  // block leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_op     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_ALU;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = SRC_B_FOUR;
      end
      S_DECODE: alu_src_b = SRC_B_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src   = PC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Combinational so a taken branch loads the PC at the end of BRANCH.
  assign pc_en      = pc_write | (branch & zero);
  assign illegal_op = (state_q == S_DECODE) && !opcode_supported(opcode);
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Randomized scoreboard bench: an instruction-level model queues the expected
// per-cycle outputs, and a negedge monitor compares them against the DUT.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic [1:0] alu_op, alu_src_b, pc_src;
  logic       alu_src_a, i_or_d, ir_write, mem_write, reg_write, reg_dst;
  logic       mem_to_reg, pc_write, branch, pc_en, illegal_op;
  logic [3:0] state;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .i_or_d(i_or_d), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .branch(branch),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] vec;
    int          st;
  } exp_t;

  exp_t q[$];
  int   path[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Strobes per state, packed {alu_op, src_a, src_b, pc_src, i_or_d, ir_write,
  // mem_write, reg_write, reg_dst, mem_to_reg, pc_write, branch}.
  function automatic logic [14:0] ctrl_for(input int s);
    logic [1:0] aop = 0, sb = 0, ps = 0;
    logic sa = 0, iod = 0, irw = 0, mw = 0, rw = 0, rd = 0, m2r = 0, pw = 0, br = 0;
    case (s)
      0:  begin irw = 1; pw = 1; sb = 2'b01; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iod = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iod = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pw = 1; end
      default: ;
    endcase
    return {aop, sa, sb, ps, iod, irw, mw, rw, rd, m2r, pw, br};
  endfunction

  task automatic build_path(input logic [5:0] op);
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b001000: path = '{0, 1, 9, 10};
      6'b000100: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 11};
      default:   path = '{0, 1};
    endcase
  endtask

  task automatic step(input int s, input logic [5:0] op, input logic z, input logic rst);
    exp_t e;
    logic [14:0] c;
    logic ill;
    opcode = op;
    zero   = z;
    rst_n  = rst;
    c   = ctrl_for(s);
    ill = (s == 1) && !(op inside {6'b100011, 6'b101011, 6'b000000,
                                   6'b000100, 6'b001000, 6'b000010});
    e.st  = s;
    e.vec = {4'(s), c, c[1] | (c[0] & z), ill};
    q.push_back(e);
  endtask

  // zero_mode / after_op < 0 mean random; abort_at indexes the path cycle in
  // which rst_n is pulled low.
  task automatic run_instr(input logic [5:0] op, input int zero_mode,
                           input int after_op, input int abort_at);
    logic [5:0] drv;
    logic z;
    build_path(op);
    for (int i = 0; i < path.size(); i++) begin
      @(posedge clk); #1;
      if (i == 1) drv = op;
      else if (i > 1 && after_op >= 0) drv = 6'(after_op);
      else drv = 6'($urandom_range(0, 63));
      z = (zero_mode >= 0) ? 1'(zero_mode) : 1'($urandom_range(0, 1));
      step(path[i], drv, z, (i == abort_at) ? 1'b0 : 1'b1);
      if (i == abort_at) break;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("state%0d_outputs", e.st),
              32'({state, alu_op, alu_src_a, alu_src_b, pc_src, i_or_d, ir_write,
                   mem_write, reg_write, reg_dst, mem_to_reg, pc_write, branch,
                   pc_en, illegal_op}),
              32'(e.vec));
      end
    end
  end

  initial begin : stimulus
    logic [5:0] op;
    @(posedge clk); #1;
    step(0, 6'd35, 1'b1, 1'b0);
    @(posedge clk); #1;
    step(0, 6'd0, 1'b0, 1'b0);

    run_instr(6'b100011, -1, -1, -1);
    run_instr(6'b000000, -1, -1, -1);
    run_instr(6'b000100, 1, -1, -1);
    run_instr(6'b000100, 0, -1, -1);
    run_instr(6'b101011, -1, 0, -1);
    run_instr(6'b100011, -1, 43, -1);
    run_instr(6'b111111, -1, -1, -1);
    run_instr(6'b001000, -1, -1, -1);
    run_instr(6'b000010, -1, -1, -1);
    run_instr(6'b100011, -1, -1, 3);
    run_instr(6'b000000, -1, -1, -1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b001000;
        5: op = 6'b000010;
        default: op = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, -1, -1,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    @(negedge clk); #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
MULTICYCLE_MAIN_CONTROL -- requirements
Module: multicycle_main_control

Interface
REQ-001 Parameters: none; opcode and state encodings are fixed constants.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 opcode  input  6  instruction[31:26], sampled only in DECODE.
REQ-006 zero  input  1  ALU zero flag, used only in BRANCH.
REQ-007 alu_op  output  2  to ALU decoder: 00 add, 01 subtract, 10 use funct field.
REQ-008 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-009 alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
REQ-010 pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-011 i_or_d, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, pc_write, branch  output  1 each  datapath strobes and selects.
REQ-012 pc_en  output  1  pc_write OR (branch AND zero).
REQ-013 illegal_op  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-014 state  output  4  current state code, for debug.

Function
REQ-015 Machine type: Moore FSM; every output except pc_en and illegal_op is a pure function of the state register.
REQ-016 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
REQ-017 Transitions:
- FETCH->DECODE.
- DECODE by opcode: 100011 or 101011 ->MEMADR; 000000 ->EXEC; 000100 ->BRANCH; 001000 ->ADDIEX; 000010 ->JUMP; any other ->FETCH.
- MEMADR: lw ->MEMRD, sw ->MEMWR.
- MEMRD->MEMWB; EXEC->ALUWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP ->FETCH.
REQ-018 Opcode hold: MEMADR shall branch on an opcode bit registered in DECODE, not on the live opcode input.
REQ-019 Output values per state; every output not listed is 0:
- FETCH: ir_write=1, pc_write=1, alu_src_b=01.
- DECODE: alu_src_b=11.
- MEMADR: alu_src_a=1, alu_src_b=10.
- MEMRD: i_or_d=1.
- MEMWB: mem_to_reg=1, reg_write=1.
- MEMWR: i_or_d=1, mem_write=1.
- EXEC: alu_src_a=1, alu_op=10.
- ALUWB: reg_dst=1, reg_write=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1.
- ADDIEX: alu_src_a=1, alu_src_b=10.
- ADDIWB: reg_write=1.
- JUMP: pc_src=10, pc_write=1.
REQ-020 pc_en shall be combinational, so a taken branch updates the PC at the end of the BRANCH cycle.
REQ-021 illegal_op shall be 1 only during a DECODE cycle whose opcode is unsupported; that instruction completes in 2 cycles as a NOP.
REQ-022 Latency (cycles, FETCH to the next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
REQ-023 Unreachable codes 12-15 shall transition to FETCH and drive all outputs to 0.

Reset
REQ-024 While rst_n=0 at a rising clk edge, the state shall become FETCH; the registered opcode bit shall clear.
REQ-025 Reset in any state, including mid-instruction, shall abort the instruction; no strobe other than the FETCH strobes shall assert until a new instruction is decoded.
REQ-026 Reset-release outputs: on the first cycle after release, ir_write=1, pc_write=1, pc_en=1, and all other strobes 0.

Structure
REQ-027 Shared package: opcode constants, state codes, and the alu_op / alu_src_b / pc_src encodings; the ALU decoder shall use the same alu_op constants.
REQ-028 Sub-modules: none; next-state and output logic live in one module with a single state register.

Verification
REQ-029 Reset release, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; mem_to_reg=1.
REQ-030 opcode=000000 -> EXEC with alu_op=10, then ALUWB with reg_dst=1 and reg_write=1; back to FETCH after 4 cycles.
REQ-031 opcode=000100 with zero=1 -> pc_en=1 in BRANCH; with zero=0 -> pc_en=0; both take 3 cycles.
REQ-032 opcode=101011 with opcode changed to 000000 after DECODE -> path still MEMADR then MEMWR, mem_write=1.
REQ-033 opcode=111111 -> illegal_op=1 for one cycle; next state FETCH; no reg_write or mem_write.
REQ-034 rst_n=0 during MEMRD -> state 0 at next edge; mem_to_reg and reg_write never assert.
